// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor that reuses one 4-bit carry-lookahead
// slice, one nibble per clock, LSB first, with valid/ready on both ends.

module Cla4 (
    input  logic [3:0] x_i,
    input  logic [3:0] y_i,
    input  logic       cin_i,
    output logic [3:0] s_o,
    output logic       cout_o
);
    logic [3:0] gen;
    logic [3:0] prop;
    logic [4:0] carry;

    // All carries are flattened from generate/propagate so the slice depth
    // does not grow with the ripple position.
    always_comb begin
        gen      = x_i & y_i;
        prop     = x_i ^ y_i;
        carry[0] = cin_i;
        carry[1] = gen[0] | (prop[0] & carry[0]);
        carry[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & carry[0]);
        carry[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
                 | (prop[2] & prop[1] & prop[0] & carry[0]);
        carry[4] = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
                 | (prop[3] & prop[2] & prop[1] & gen[0]) | ((&prop) & carry[0]);
        s_o      = prop ^ carry[3:0];
        cout_o   = carry[4];
    end
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid_i,
    output logic             start_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic             done_valid_o,
    input  logic             done_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_out_o,
    output logic             overflow_o
);
    localparam int N  = WIDTH / 4;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] LAST_K = KW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] opA_q, opA_d;
    logic [WIDTH-1:0] opB_q, opB_d;
    logic             subOp_q, subOp_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carryOut_q, carryOut_d;
    logic             overflow_q, overflow_d;

    logic [3:0] sliceX;
    logic [3:0] sliceY;
    logic [3:0] sliceS;
    logic       sliceCout;

    // Subtraction is A + ~B + 1: invert B per nibble and seed the carry with sub.
    always_comb begin
        sliceX = opA_q[4*k_q +: 4];
        sliceY = opB_q[4*k_q +: 4] ^ {4{subOp_q}};
    end

    Cla4 u_slice (
        .x_i    (sliceX),
        .y_i    (sliceY),
        .cin_i  (carry_q),
        .s_o    (sliceS),
        .cout_o (sliceCout)
    );

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        opA_d      = opA_q;
        opB_d      = opB_q;
        subOp_d    = subOp_q;
        carry_d    = carry_q;
        result_d   = result_q;
        carryOut_d = carryOut_q;
        overflow_d = overflow_q;
        case (state_q)
            IDLE: begin
                if (start_valid_i) begin
                    state_d  = RUN;
                    opA_d    = a_i;
                    opB_d    = b_i;
                    subOp_d  = sub_i;
                    k_d      = '0;
                    result_d = '0;
                    carry_d  = sub_i;
                end
            end
            RUN: begin
                result_d[4*k_q +: 4] = sliceS;
                carry_d              = sliceCout;
                // k holds at the last nibble instead of wrapping; accept clears it.
                if (k_q == LAST_K) begin
                    state_d    = DONE;
                    carryOut_d = sliceCout;
                    overflow_d = (opA_q[WIDTH-1] == (opB_q[WIDTH-1] ^ subOp_q))
                               && (sliceS[3] != opA_q[WIDTH-1]);
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                if (done_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            k_q        <= '0;
            opA_q      <= '0;
            opB_q      <= '0;
            subOp_q    <= 1'b0;
            carry_q    <= 1'b0;
            result_q   <= '0;
            carryOut_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            opA_q      <= opA_d;
            opB_q      <= opB_d;
            subOp_q    <= subOp_d;
            carry_q    <= carry_d;
            result_q   <= result_d;
            carryOut_q <= carryOut_d;
            overflow_q <= overflow_d;
        end
    end

    assign start_ready_o = (state_q == IDLE);
    assign done_valid_o  = (state_q == DONE);
    assign result_o      = result_q;
    assign carry_out_o   = carryOut_q;
    assign overflow_o    = overflow_q;
endmodule
